lfsr_sched: RTL and testbench

Arbitrating scheduler that shares one 8-bit Fibonacci LFSR among NREQ requesters. Grants the generator round-robin in bursts of up to BURST words over a valid/ready handshake. Handles seed loading and zero-seed protection. Sits between the LFSR datapath and the blocks consuming pseudo-random bytes; the LFSR advances only on accepted words, so every consumer sees a deterministic, gap-free sequence slice.

---
 rtl/lfsr_pkg.sv | 23 ++
 rtl/lfsr8_core.sv | 37 +++
 rtl/lfsr_sched.sv | 123 ++++++++++++
 tb/tb_lfsr_sched.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants, FSM state type and LFSR step function for the
// pseudo-random byte scheduler.
package lfsr_pkg;

  localparam int unsigned LFSR_W = 8;

  // Taps at bits 7,5,4,3: x^8+x^6+x^5+x^4+1, maximal length (255 states).
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    SERVE
  } sched_state_t;

  // One Fibonacci step: shift left, feedback is the parity of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr8_core.sv
// 8-bit Fibonacci LFSR register with step/load control. A zero load value
// would lock the generator, so it is replaced by DEFAULT_SEED and flagged.
module lfsr8_core
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_value,
  output logic [LFSR_W-1:0] q,
  output logic              lockup
);

  // LFSR state: load has priority over step; lockup pulses for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q      <= DEFAULT_SEED;
      lockup <= 1'b0;
    end else begin
      lockup <= 1'b0;
      if (load) begin
        if (load_value == '0) begin
          q      <= DEFAULT_SEED;
          lockup <= 1'b1;
        end else begin
          q <= load_value;
        end
      end else if (step) begin
        q <= lfsr_next(q);
      end
    end
  end

endmodule

// File: rtl/lfsr_sched.sv
// Round-robin scheduler sharing one LFSR among NREQ requesters in bursts of
// up to BURST words over a valid/ready handshake. The LFSR only advances on
// accepted words, so each consumer receives a gap-free slice of the sequence.
module lfsr_sched
  import lfsr_pkg::*;
#(
  parameter int unsigned       NREQ         = 4,
  parameter int unsigned       BURST        = 4,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic [LFSR_W-1:0] rnd_data,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              busy,
  output logic              lockup
);

  localparam int unsigned       PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned       CNT_W    = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(NREQ - 1);

  sched_state_t     state;
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] win_idx;
  logic             win_found;
  logic             handshake;
  logic             lfsr_load;
  logic             winner_req;

  assign handshake  = rnd_valid & rnd_ready;
  // Seed loads are only honoured outside SERVE so a burst never changes mid-stream.
  assign lfsr_load  = seed_load & (state != SERVE);
  assign winner_req = |(req & gnt);

  lfsr8_core #(
    .DEFAULT_SEED(DEFAULT_SEED)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .step      (handshake),
    .load      (lfsr_load),
    .load_value(seed),
    .q         (rnd_data),
    .lockup    (lockup)
  );

  // Round-robin search: first set request at or above ptr, wrapping around.
  always_comb begin
    logic [PTR_W-1:0] k;
    k         = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = PTR_W'((ptr + i) % NREQ);
      if (!win_found && req[k]) begin
        win_found = 1'b1;
        win_idx   = k;
      end
    end
  end

  // Scheduler FSM with registered grant, valid and busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      count     <= '0;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) state <= ARB;
        end
        ARB: begin
          if (!enable) begin
            state <= IDLE;
          end else if (win_found) begin
            gnt       <= NREQ'(1) << win_idx;
            ptr       <= (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
            count     <= '0;
            rnd_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SERVE;
          end
        end
        SERVE: begin
          if (handshake) begin
            count <= count + 1'b1;
            if (count == CNT_LAST) begin
              gnt       <= '0;
              rnd_valid <= 1'b0;
              busy      <= 1'b0;
              state     <= ARB;
            end
          end else if (!winner_req) begin
            gnt       <= '0;
            rnd_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ARB;
          end
        end
        default: begin
          gnt       <= '0;
          rnd_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_sched.sv
// Self-checking bench for lfsr_sched: directed vector table, hand-written
// corner-case sequences and a randomized run against a sequence-position model.
module tb_lfsr_sched;

  localparam int NREQ  = 4;
  localparam int BURST = 4;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       seed_load;
  logic [7:0] seed;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [7:0] rnd_data;
  logic       rnd_valid;
  logic       rnd_ready;
  logic       busy;
  logic       lockup;

  lfsr_sched #(
    .NREQ (NREQ),
    .BURST(BURST),
    .DEFAULT_SEED(8'h01)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .seed_load(seed_load),
    .seed     (seed),
    .req      (req),
    .gnt      (gnt),
    .rnd_data (rnd_data),
    .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready),
    .busy     (busy),
    .lockup   (lockup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: the maximal-length sequence as a table, the model tracks a position in it.
  int seq[255];
  int idx_of[256];

  int m_win;    // -1 when no requester is being served
  int m_arb;    // 1 while arbitrating (only meaningful when m_win < 0)
  int m_ptr;
  int m_taken;
  int m_pos;
  int m_lock;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void build_seq();
    int v;
    v = 1;
    for (int i = 0; i < 255; i++) begin
      seq[i]    = v;
      idx_of[v] = i;
      v = ((v << 1) & 255) | (((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1);
    end
  endfunction

  function automatic void model_reset();
    m_win = -1; m_arb = 0; m_ptr = 0; m_taken = 0; m_pos = 0; m_lock = 0;
  endfunction

  function automatic void model_step(input logic e, input logic [3:0] r, input logic rd,
                                     input logic s, input logic [7:0] sv);
    bit found;
    int w;
    m_lock = 0;
    if (m_win >= 0) begin
      if (rd) begin
        m_pos = (m_pos + 1) % 255;
        m_taken++;
        if (m_taken == BURST) begin m_win = -1; m_arb = 1; end
      end else if (!r[m_win]) begin
        m_win = -1; m_arb = 1;
      end
    end else begin
      if (s) begin
        if (sv == 0) begin m_pos = 0; m_lock = 1; end
        else m_pos = idx_of[sv];
      end
      if (m_arb == 0) begin
        if (e) m_arb = 1;
      end else if (!e) begin
        m_arb = 0;
      end else begin
        found = 0;
        for (int k = 0; k < NREQ; k++) begin
          w = (m_ptr + k) % NREQ;
          if (!found && r[w]) begin
            found = 1; m_win = w; m_ptr = (w + 1) % NREQ; m_taken = 0; m_arb = 0;
          end
        end
      end
    end
  endfunction

  function automatic void compare_all();
    check("gnt",       32'(gnt),       (m_win >= 0) ? 32'(1 << m_win) : 32'd0);
    check("rnd_valid", 32'(rnd_valid), (m_win >= 0) ? 32'd1 : 32'd0);
    check("busy",      32'(busy),      (m_win >= 0) ? 32'd1 : 32'd0);
    check("rnd_data",  32'(rnd_data),  32'(seq[m_pos]));
    check("lockup",    32'(lockup),    32'(m_lock));
  endfunction

  // One clock: drive inputs, advance model at the edge, compare just after it.
  task automatic run(input logic e, input logic [3:0] r, input logic rd,
                     input logic s, input logic [7:0] sv);
    enable = e; req = r; rnd_ready = rd; seed_load = s; seed = sv;
    @(posedge clk);
    model_step(e, r, rd, s, sv);
    #1;
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_gnt"},   32'(gnt),       32'd0);
    check({tag, "_valid"}, 32'(rnd_valid), 32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_data"},  32'(rnd_data),  32'h01);
    check({tag, "_lock"},  32'(lockup),    32'd0);
  endtask

  // Entered just after an edge; reset acts without any clock edge.
  task automatic rst_dut();
    enable = 0; req = '0; rnd_ready = 0; seed_load = 0; seed = '0;
    reset = 1'b1;
    #1;
    check_reset_values("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic       en;
    logic [3:0] rq;
    logic       rdy;
    logic       sl;
    logic [7:0] sd;
    logic [3:0] e_gnt;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_lock;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    int len;
    logic [3:0] r;
    logic       s;
    logic [7:0] sv;

    build_seq();
    model_reset();
    enable = 0; req = '0; rnd_ready = 0; seed_load = 0; seed = '0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_values("por");
    reset = 1'b0;

    // Single requester, ready high: 01,02,04,08, one ARB gap, then 11,23.
    vecs[0] = '{1'b1, 4'b0001, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 8'h01, 1'b0};
    vecs[1] = '{1'b1, 4'b0001, 1'b1, 1'b0, 8'h00, 4'b0001, 1'b1, 8'h01, 1'b0};
    vecs[2] = '{1'b1, 4'b0001, 1'b1, 1'b0, 8'h00, 4'b0001, 1'b1, 8'h02, 1'b0};
    vecs[3] = '{1'b1, 4'b0001, 1'b1, 1'b0, 8'h00, 4'b0001, 1'b1, 8'h04, 1'b0};
    vecs[4] = '{1'b1, 4'b0001, 1'b1, 1'b0, 8'h00, 4'b0001, 1'b1, 8'h08, 1'b0};
    vecs[5] = '{1'b1, 4'b0001, 1'b1, 1'b0, 8'h00, 4'b0000, 1'b0, 8'h11, 1'b0};
    vecs[6] = '{1'b1, 4'b0001, 1'b1, 1'b0, 8'h00, 4'b0001, 1'b1, 8'h11, 1'b0};
    vecs[7] = '{1'b1, 4'b0001, 1'b1, 1'b0, 8'h00, 4'b0001, 1'b1, 8'h23, 1'b0};
    for (int i = 0; i < 8; i++) begin
      run(vecs[i].en, vecs[i].rq, vecs[i].rdy, vecs[i].sl, vecs[i].sd);
      check("vec_gnt",   32'(gnt),       32'(vecs[i].e_gnt));
      check("vec_valid", 32'(rnd_valid), 32'(vecs[i].e_valid));
      check("vec_data",  32'(rnd_data),  32'(vecs[i].e_data));
      check("vec_lock",  32'(lockup),    32'(vecs[i].e_lock));
    end

    // Round-robin with all requesting: 0001,0010,0100,1000,0001, 4 words, 1-cycle gaps.
    rst_dut();
    for (int b = 0; b < 5; b++) begin
      n = 0;
      while (!rnd_valid && n < 5) begin run(1, 4'b1111, 1, 0, 0); n++; end
      check("rr_gnt", 32'(gnt), 32'(1 << (b % 4)));
      if (b > 0) check("rr_gap", 32'(n), 32'd1);
      len = 0;
      while (rnd_valid && len < 10) begin len++; run(1, 4'b1111, 1, 0, 0); end
      check("rr_len", 32'(len), 32'(BURST));
    end

    // Backpressure: three stalled cycles hold data and grant.
    rst_dut();
    run(1, 4'b0001, 1, 0, 0);
    run(1, 4'b0001, 1, 0, 0);
    check("bp_first", 32'(rnd_data), 32'h01);
    run(1, 4'b0001, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      run(1, 4'b0001, 0, 0, 0);
      check("bp_hold_data", 32'(rnd_data), 32'h02);
      check("bp_hold_gnt",  32'(gnt),      32'b0001);
    end
    run(1, 4'b0001, 1, 0, 0);
    check("bp_w3", 32'(rnd_data), 32'h04);
    run(1, 4'b0001, 1, 0, 0);
    check("bp_w4", 32'(rnd_data), 32'h08);
    run(1, 4'b0001, 1, 0, 0);
    check("bp_end", 32'(rnd_valid), 32'd0);

    // Early release: requester 1 drops after two words, next grant to requester 2.
    rst_dut();
    run(1, 4'b0110, 0, 0, 0);
    run(1, 4'b0110, 0, 0, 0);
    check("er_gnt1", 32'(gnt), 32'b0010);
    run(1, 4'b0110, 1, 0, 0);
    run(1, 4'b0110, 1, 0, 0);
    run(1, 4'b0100, 0, 0, 0);
    check("er_release", 32'(rnd_valid), 32'd0);
    run(1, 4'b0100, 0, 0, 0);
    check("er_gnt2",  32'(gnt),      32'b0100);
    check("er_data2", 32'(rnd_data), 32'h04);

    // Zero seed in ARB with simultaneous grant; seed during SERVE ignored.
    rst_dut();
    run(1, 4'b0000, 0, 0, 0);
    run(1, 4'b0001, 0, 1, 8'h00);
    check("zs_lock", 32'(lockup),   32'd1);
    check("zs_data", 32'(rnd_data), 32'h01);
    check("zs_gnt",  32'(gnt),      32'b0001);
    run(1, 4'b0001, 0, 1, 8'h5A);
    check("zs_lock_pulse", 32'(lockup),   32'd0);
    check("serve_seed_ign", 32'(rnd_data), 32'h01);
    run(1, 4'b0001, 1, 0, 0);
    check("serve_seed_next", 32'(rnd_data), 32'h02);

    // Seed loaded in IDLE becomes the first word of the next burst.
    rst_dut();
    run(0, 4'b0000, 0, 1, 8'h5A);
    check("idle_seed", 32'(rnd_data), 32'h5A);
    run(1, 4'b0001, 0, 0, 0);
    run(1, 4'b0001, 0, 0, 0);
    check("idle_seed_first", 32'(rnd_data), 32'h5A);
    check("idle_seed_valid", 32'(rnd_valid), 32'd1);

    // Asynchronous reset in the middle of a burst.
    run(1, 4'b0001, 1, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      s  = ($urandom_range(0, 19) == 0);
      sv = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      run(($urandom_range(0, 19) != 0), r, ($urandom_range(0, 9) < 7), s, sv);
      if (c == 1500) rst_dut();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
